// File: rtl/autosa_csb2mcif_req_master.sv
// rtl/autosa_csb2mcif_req_master.sv - host-side request master for the MCIF CSB register slave
//
// Purpose: accepts one register command at a time from the host router, packs it
// into the 63-bit csb2mcif request packet, issues it over pvld/prdy, then waits for
// the slave's 34-bit response (or a timeout) and hands it back to the host.
//
// Ports:
//   autosa_core_clk / autosa_core_rst  clock, synchronous active-high reset
//   host_req_*                         host command channel (valid/ready)
//   host_rsp_*                         host response channel (valid/ready)
//   csb2mcif_req_pvld/prdy/pd          request packet to the slave
//   mcif2csb_resp_valid/pd             single-cycle response pulse from the slave
//   busy                               transaction in progress
//   stray_rsp_cnt                      saturating count of unexpected responses
module autosa_csb2mcif_req_master #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [1:0]  LEVEL       = 2'b00,
  parameter logic        SRCPRIV     = 1'b0
) (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rst,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic [21:0] host_req_addr,
  input  logic [31:0] host_req_wdat,
  input  logic        host_req_write,
  input  logic        host_req_nposted,
  input  logic [3:0]  host_req_wrbe,
  output logic        host_rsp_valid,
  input  logic        host_rsp_ready,
  output logic [31:0] host_rsp_rdat,
  output logic        host_rsp_error,
  output logic        host_rsp_is_write,
  output logic        csb2mcif_req_pvld,
  input  logic        csb2mcif_req_prdy,
  output logic [62:0] csb2mcif_req_pd,
  input  logic        mcif2csb_resp_valid,
  input  logic [33:0] mcif2csb_resp_pd,
  output logic        busy,
  output logic [7:0]  stray_rsp_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RSP} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [62:0] pd_q;
  logic        exp_write_q;
  logic        posted_q;
  logic [15:0] timer_q;
  logic [31:0] rdat_q;
  logic        err_q;
  logic        wr_q;
  logic        drop_pending_q;
  logic [7:0]  stray_q;

  logic req_fire;
  logic issue_fire;
  logic rsp_in_wait;
  logic timeout_hit;

  assign req_fire    = (state == IDLE) && host_req_valid;
  assign issue_fire  = (state == ISSUE) && csb2mcif_req_prdy;
  assign rsp_in_wait = (state == WAIT_RSP) && mcif2csb_resp_valid;
  // A response in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT_RSP) && !mcif2csb_resp_valid && (timer_q == TIMER_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (host_req_valid) state_nxt = ISSUE;
      ISSUE:    if (csb2mcif_req_prdy) state_nxt = posted_q ? IDLE : WAIT_RSP;
      WAIT_RSP: if (rsp_in_wait || timeout_hit) state_nxt = RSP;
      RSP:      if (host_rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state          <= IDLE;
      pd_q           <= '0;
      exp_write_q    <= 1'b0;
      posted_q       <= 1'b0;
      timer_q        <= '0;
      rdat_q         <= '0;
      err_q          <= 1'b0;
      wr_q           <= 1'b0;
      drop_pending_q <= 1'b0;
      stray_q        <= '0;
    end else begin
      state <= state_nxt;

      if (req_fire) begin
        // Reads never carry the non-posted flag.
        pd_q <= {LEVEL, host_req_wrbe, SRCPRIV, host_req_nposted & host_req_write,
                 host_req_write, host_req_wdat, host_req_addr};
        exp_write_q <= host_req_write;
        posted_q    <= host_req_write & ~host_req_nposted;
      end

      if (issue_fire) begin
        timer_q <= '0;
      end else if (state == WAIT_RSP) begin
        timer_q <= timer_q + 16'd1;
      end

      if (rsp_in_wait) begin
        rdat_q <= mcif2csb_resp_pd[31:0];
        wr_q   <= mcif2csb_resp_pd[33];
        err_q  <= mcif2csb_resp_pd[32] | (mcif2csb_resp_pd[33] != exp_write_q);
      end else if (timeout_hit) begin
        rdat_q <= '0;
        wr_q   <= exp_write_q;
        err_q  <= 1'b1;
      end

      // After a timeout the slave may still answer; that one late response is
      // swallowed instead of being counted as stray.
      if (mcif2csb_resp_valid && ((state == WAIT_RSP) || drop_pending_q)) begin
        drop_pending_q <= 1'b0;
      end else if (timeout_hit) begin
        drop_pending_q <= 1'b1;
      end

      if (mcif2csb_resp_valid && (state != WAIT_RSP) && !drop_pending_q && (stray_q != 8'hFF)) begin
        stray_q <= stray_q + 8'd1;
      end
    end
  end

  assign host_req_ready    = (state == IDLE);
  assign csb2mcif_req_pvld = (state == ISSUE);
  assign csb2mcif_req_pd   = pd_q;
  assign host_rsp_valid    = (state == RSP);
  assign host_rsp_rdat     = (state == RSP) ? rdat_q : 32'h0;
  assign host_rsp_error    = err_q;
  assign host_rsp_is_write = wr_q;
  assign busy              = (state != IDLE);
  assign stray_rsp_cnt     = stray_q;

endmodule

// File: tb/tb_autosa_csb2mcif_req_master.sv
// tb/tb_autosa_csb2mcif_req_master.sv - directed self-checking bench for autosa_csb2mcif_req_master
module tb_autosa_csb2mcif_req_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req_valid;
  logic        host_req_ready;
  logic [21:0] host_req_addr;
  logic [31:0] host_req_wdat;
  logic        host_req_write;
  logic        host_req_nposted;
  logic [3:0]  host_req_wrbe;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [31:0] host_rsp_rdat;
  logic        host_rsp_error;
  logic        host_rsp_is_write;
  logic        pvld;
  logic        prdy;
  logic [62:0] pd;
  logic        resp_valid;
  logic [33:0] resp_pd;
  logic        busy;
  logic [7:0]  stray;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  autosa_csb2mcif_req_master #(.TIMEOUT_CYC(8), .LEVEL(2'b00), .SRCPRIV(1'b0)) dut (
    .autosa_core_clk     (clk),
    .autosa_core_rst     (rst),
    .host_req_valid      (host_req_valid),
    .host_req_ready      (host_req_ready),
    .host_req_addr       (host_req_addr),
    .host_req_wdat       (host_req_wdat),
    .host_req_write      (host_req_write),
    .host_req_nposted    (host_req_nposted),
    .host_req_wrbe       (host_req_wrbe),
    .host_rsp_valid      (host_rsp_valid),
    .host_rsp_ready      (host_rsp_ready),
    .host_rsp_rdat       (host_rsp_rdat),
    .host_rsp_error      (host_rsp_error),
    .host_rsp_is_write   (host_rsp_is_write),
    .csb2mcif_req_pvld   (pvld),
    .csb2mcif_req_prdy   (prdy),
    .csb2mcif_req_pd     (pd),
    .mcif2csb_resp_valid (resp_valid),
    .mcif2csb_resp_pd    (resp_pd),
    .busy                (busy),
    .stray_rsp_cnt       (stray)
  );

  // Presents one command for a single cycle; returns at the negedge of cycle 1.
  task automatic accept(input logic [21:0] a, input logic [31:0] d, input logic w,
                        input logic np, input logic [3:0] be);
    host_req_addr    = a;
    host_req_wdat    = d;
    host_req_write   = w;
    host_req_nposted = np;
    host_req_wrbe    = be;
    host_req_valid   = 1'b1;
    @(negedge clk);
    host_req_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (host_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got %b want 1", host_req_ready); end
    n_cmp++; if (pvld !== 1'b0) begin n_bad++; $display("FAIL rst_pvld got %b want 0", pvld); end
    n_cmp++; if (pd !== 63'h0) begin n_bad++; $display("FAIL rst_pd got %h want 0", pd); end
    n_cmp++; if (host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0", host_rsp_valid); end
    n_cmp++; if (host_rsp_rdat !== 32'h0) begin n_bad++; $display("FAIL rst_rdat got %h want 0", host_rsp_rdat); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (stray !== 8'h0) begin n_bad++; $display("FAIL rst_stray got %0d want 0", stray); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [62:0] exp_pd;
    exp_pd = {2'b00, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 22'h000004};
    accept(22'h000004, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++; if (pvld !== 1'b1) begin n_bad++; $display("FAIL rd_pvld got %b want 1", pvld); end
    n_cmp++; if (pd !== exp_pd) begin n_bad++; $display("FAIL rd_pd got %h want %h", pd, exp_pd); end
    n_cmp++; if (host_req_ready !== 1'b0) begin n_bad++; $display("FAIL rd_req_ready got %b want 0", host_req_ready); end
    @(negedge clk);
    n_cmp++; if (pvld !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rd_wait got pvld=%b busy=%b want 0/1", pvld, busy); end
    @(negedge clk);
    n_cmp++; if (host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early_rsp got %b want 0", host_rsp_valid); end
    resp_pd = 34'h0_0000_0008; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (host_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid got %b want 1", host_rsp_valid); end
    n_cmp++; if (host_rsp_rdat !== 32'h8) begin n_bad++; $display("FAIL rd_rdat got %h want 8", host_rsp_rdat); end
    n_cmp++; if (host_rsp_error !== 1'b0 || host_rsp_is_write !== 1'b0) begin n_bad++; $display("FAIL rd_flags got err=%b wr=%b want 0/0", host_rsp_error, host_rsp_is_write); end
    @(negedge clk);
    n_cmp++; if (host_rsp_valid !== 1'b0 || busy !== 1'b0 || host_rsp_rdat !== 32'h0) begin n_bad++; $display("FAIL rd_done got v=%b busy=%b rdat=%h want 0/0/0", host_rsp_valid, busy, host_rsp_rdat); end
  endtask

  task automatic test_np_write();
    logic [62:0] exp_pd;
    exp_pd = {2'b00, 4'h3, 1'b0, 1'b1, 1'b1, 32'h0000_00A5, 22'h000010};
    accept(22'h000010, 32'h0000_00A5, 1'b1, 1'b1, 4'h3);
    n_cmp++; if (pd[55:54] !== 2'b11) begin n_bad++; $display("FAIL npw_flags got %b want 11", pd[55:54]); end
    n_cmp++; if (pd[53:22] !== 32'hA5) begin n_bad++; $display("FAIL npw_wdat got %h want a5", pd[53:22]); end
    n_cmp++; if (pd !== exp_pd) begin n_bad++; $display("FAIL npw_pd got %h want %h", pd, exp_pd); end
    @(negedge clk);
    @(negedge clk);
    resp_pd = 34'h2_0000_0000; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_is_write !== 1'b1) begin n_bad++; $display("FAIL npw_rsp got v=%b wr=%b want 1/1", host_rsp_valid, host_rsp_is_write); end
    n_cmp++; if (host_rsp_error !== 1'b0 || host_rsp_rdat !== 32'h0) begin n_bad++; $display("FAIL npw_data got err=%b rdat=%h want 0/0", host_rsp_error, host_rsp_rdat); end
    @(negedge clk);
  endtask

  task automatic test_posted_write();
    accept(22'h000020, 32'h0000_5A5A, 1'b1, 1'b0, 4'hF);
    n_cmp++; if (pvld !== 1'b1 || pd[55:54] !== 2'b01) begin n_bad++; $display("FAIL pw_issue got pvld=%b flags=%b want 1/01", pvld, pd[55:54]); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || host_req_ready !== 1'b1) begin n_bad++; $display("FAIL pw_idle got busy=%b ready=%b want 0/1", busy, host_req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL pw_no_rsp got %b want 0", host_rsp_valid); end
    end
    resp_pd = 34'h2_0000_0000; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (stray !== 8'd1) begin n_bad++; $display("FAIL pw_stray got %0d want 1", stray); end
  endtask

  task automatic test_timeout();
    do_reset();
    accept(22'h000008, 32'h0, 1'b0, 1'b0, 4'hF);
    repeat (8) @(negedge clk);
    n_cmp++; if (host_rsp_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_early got v=%b busy=%b want 0/1", host_rsp_valid, busy); end
    @(negedge clk);
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_error !== 1'b1) begin n_bad++; $display("FAIL to_rsp got v=%b err=%b want 1/1", host_rsp_valid, host_rsp_error); end
    n_cmp++; if (host_rsp_rdat !== 32'h0 || host_rsp_is_write !== 1'b0) begin n_bad++; $display("FAIL to_data got rdat=%h wr=%b want 0/0", host_rsp_rdat, host_rsp_is_write); end
    @(negedge clk);
    resp_pd = 34'h0_0000_00FF; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (stray !== 8'd0) begin n_bad++; $display("FAIL to_late_drop got %0d want 0", stray); end
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (stray !== 8'd1) begin n_bad++; $display("FAIL to_second_stray got %0d want 1", stray); end
  endtask

  task automatic test_timeout_race();
    accept(22'h00000C, 32'h0, 1'b0, 1'b0, 4'hF);
    repeat (8) @(negedge clk);
    resp_pd = 34'h0_1234_5678; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_error !== 1'b0) begin n_bad++; $display("FAIL race_rsp got v=%b err=%b want 1/0", host_rsp_valid, host_rsp_error); end
    n_cmp++; if (host_rsp_rdat !== 32'h1234_5678) begin n_bad++; $display("FAIL race_rdat got %h want 12345678", host_rsp_rdat); end
    @(negedge clk);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (stray !== 8'd2) begin n_bad++; $display("FAIL race_stray got %0d want 2", stray); end
  endtask

  task automatic test_backpressure();
    logic [62:0] exp_pd;
    exp_pd = {2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 22'h3FFFFF};
    prdy = 1'b0;
    host_rsp_ready = 1'b0;
    accept(22'h3FFFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pvld !== 1'b1 || pd !== exp_pd) begin n_bad++; $display("FAIL bp_hold got pvld=%b pd=%h want 1/%h", pvld, pd, exp_pd); end
      @(negedge clk);
    end
    n_cmp++; if (pvld !== 1'b1 || pd !== exp_pd) begin n_bad++; $display("FAIL bp_hold_last got pvld=%b pd=%h want 1/%h", pvld, pd, exp_pd); end
    prdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (pvld !== 1'b0) begin n_bad++; $display("FAIL bp_issued got %b want 0", pvld); end
    @(negedge clk);
    resp_pd = 34'h0_DEAD_BEEF; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_rdat !== 32'hDEAD_BEEF || host_req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_rsp_hold got v=%b rdat=%h ready=%b want 1/deadbeef/0", host_rsp_valid, host_rsp_rdat, host_req_ready);
      end
      if (i < 4) @(negedge clk);
    end
    host_rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_rsp_valid !== 1'b0 || host_rsp_rdat !== 32'h0 || host_req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got v=%b rdat=%h ready=%b want 0/0/1", host_rsp_valid, host_rsp_rdat, host_req_ready); end
  endtask

  task automatic test_mismatch_reset();
    accept(22'h000044, 32'h0, 1'b0, 1'b0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    resp_pd = 34'h2_0000_1234; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (host_rsp_error !== 1'b1 || host_rsp_is_write !== 1'b1) begin n_bad++; $display("FAIL mm_flags got err=%b wr=%b want 1/1", host_rsp_error, host_rsp_is_write); end
    n_cmp++; if (host_rsp_rdat !== 32'h1234) begin n_bad++; $display("FAIL mm_rdat got %h want 1234", host_rsp_rdat); end
    @(negedge clk);
    accept(22'h000048, 32'h0, 1'b0, 1'b0, 4'hF);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || pvld !== 1'b0) begin n_bad++; $display("FAIL mr_wait got busy=%b pvld=%b want 1/0", busy, pvld); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (host_req_ready !== 1'b1 || busy !== 1'b0 || pvld !== 1'b0) begin n_bad++; $display("FAIL mr_ctl got ready=%b busy=%b pvld=%b want 1/0/0", host_req_ready, busy, pvld); end
    n_cmp++; if (pd !== 63'h0 || host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mr_pd got pd=%h v=%b want 0/0", pd, host_rsp_valid); end
    n_cmp++; if (host_rsp_error !== 1'b0 || host_rsp_is_write !== 1'b0 || host_rsp_rdat !== 32'h0) begin n_bad++; $display("FAIL mr_rsp got err=%b wr=%b rdat=%h want 0/0/0", host_rsp_error, host_rsp_is_write, host_rsp_rdat); end
    n_cmp++; if (stray !== 8'd0) begin n_bad++; $display("FAIL mr_stray got %0d want 0", stray); end
    resp_pd = 34'h0_0000_0001; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (stray !== 8'd1) begin n_bad++; $display("FAIL mr_late_stray got %0d want 1", stray); end
  endtask

  initial begin
    rst              = 1'b1;
    host_req_valid   = 1'b0;
    host_req_addr    = '0;
    host_req_wdat    = '0;
    host_req_write   = 1'b0;
    host_req_nposted = 1'b0;
    host_req_wrbe    = '0;
    host_rsp_ready   = 1'b1;
    prdy             = 1'b1;
    resp_valid       = 1'b0;
    resp_pd          = '0;
    test_reset();
    test_read();
    test_np_write();
    test_posted_write();
    test_timeout();
    test_timeout_race();
    test_backpressure();
    test_mismatch_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
